// File: rtl/alu_arb_if.sv
// alu_arb_if
// ----------
// Bundles the request, ALU and response channels of the shared-ALU arbiter.
//
// Handshake rule for both channels: a transfer happens on the rising clock
// edge where valid and ready are both high for the same port. A requester
// keeps every request field stable while valid is high and ready is low.
// Valid never waits for ready.
//
// Signals:
//   req_valid/req_ready      per-port request handshake (2 bits each)
//   req_rs1_*/req_rs2_*      per-port operands
//   req_opcode_*/funct3_*/funct7_*  per-port control fields, passed through
//   alu_rs1/alu_rs2/alu_*    registered operands and controls to the ALU
//   alu_rd                   combinational ALU result
//   resp_valid/resp_ready    per-port response handshake (2 bits each)
//   resp_data                result, shared by both ports
//
// Modports:
//   slave  - the arbiter
//   master - the environment: the requesters plus the ALU
interface alu_arb_if #(
   parameter int XLEN = 32,
   parameter int OPW  = 7,
   parameter int F3W  = 3,
   parameter int F7W  = 7
);
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [XLEN-1:0] req_rs1_0;
   logic [XLEN-1:0] req_rs2_0;
   logic [XLEN-1:0] req_rs1_1;
   logic [XLEN-1:0] req_rs2_1;
   logic [OPW-1:0]  req_opcode_0;
   logic [OPW-1:0]  req_opcode_1;
   logic [F3W-1:0]  req_funct3_0;
   logic [F3W-1:0]  req_funct3_1;
   logic [F7W-1:0]  req_funct7_0;
   logic [F7W-1:0]  req_funct7_1;
   logic [XLEN-1:0] alu_rs1;
   logic [XLEN-1:0] alu_rs2;
   logic [OPW-1:0]  alu_opcode;
   logic [F3W-1:0]  alu_funct3;
   logic [F7W-1:0]  alu_funct7;
   logic [XLEN-1:0] alu_rd;
   logic [1:0]      resp_valid;
   logic [1:0]      resp_ready;
   logic [XLEN-1:0] resp_data;

   modport slave (
      input  req_valid, req_rs1_0, req_rs2_0, req_rs1_1, req_rs2_1,
      input  req_opcode_0, req_opcode_1, req_funct3_0, req_funct3_1,
      input  req_funct7_0, req_funct7_1, alu_rd, resp_ready,
      output req_ready, alu_rs1, alu_rs2, alu_opcode, alu_funct3, alu_funct7,
      output resp_valid, resp_data
   );

   modport master (
      output req_valid, req_rs1_0, req_rs2_0, req_rs1_1, req_rs2_1,
      output req_opcode_0, req_opcode_1, req_funct3_0, req_funct3_1,
      output req_funct7_0, req_funct7_1, alu_rd, resp_ready,
      input  req_ready, alu_rs1, alu_rs2, alu_opcode, alu_funct3, alu_funct7,
      input  resp_valid, resp_data
   );
endinterface

// File: rtl/alu_arb.sv
// alu_arb
// -------
// Two-port arbiter and sequencer for the shared integer ALU. It keeps one
// operation in flight at a time:
//   IDLE -> EXEC  a request is accepted and its fields are registered onto
//                 the ALU input bus
//   EXEC -> RESP  the ALU's combinational result is captured into resp_data
//   RESP -> IDLE  the owner accepts the response, or RESP -> EXEC when
//                 another request is accepted on that same edge
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous, active-low reset
//   bus        alu_arb_if.slave: request, ALU and response channels
//   busy       high whenever the FSM is not in IDLE
//   dbg_state  current FSM state (IDLE=0, EXEC=1, RESP=2)
//
// Build option:
//   ALU_ARB_ROUND_ROBIN_EN  when defined, a tie goes to the port that did not
//                           win last time. When undefined, port 0 always
//                           wins a tie and port 1 can starve.
module alu_arb #(
   parameter int XLEN = 32,
   parameter int OPW  = 7,
   parameter int F3W  = 3,
   parameter int F7W  = 7
) (
   input  logic          clk,
   input  logic          rst,
   alu_arb_if.slave      bus,
   output logic          busy,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            owner_q, owner_d;
   logic [XLEN-1:0] alu_rs1_q, alu_rs1_d;
   logic [XLEN-1:0] alu_rs2_q, alu_rs2_d;
   logic [OPW-1:0]  alu_opcode_q, alu_opcode_d;
   logic [F3W-1:0]  alu_funct3_q, alu_funct3_d;
   logic [F7W-1:0]  alu_funct7_q, alu_funct7_d;
   logic [XLEN-1:0] resp_data_q, resp_data_d;
   logic [1:0]      resp_valid_q, resp_valid_d;
   logic            busy_q, busy_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
   logic            last_grant_q, last_grant_d;
`endif

   logic            winner;
   logic            can_accept;
   logic            accept;
   logic [1:0]      req_ready;

   // Arbitration, acceptance and the combinational req_ready.
   always_comb begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      // On a tie the port that did not win last time goes first.
      if (bus.req_valid == 2'b11) begin
         winner = ~last_grant_q;
      end else begin
         winner = ~bus.req_valid[0];
      end
`else
      winner = ~bus.req_valid[0];
`endif
      // A new op may start from IDLE, or from RESP on the very edge the
      // current owner takes its result (back-to-back issue).
      can_accept = (state_q == IDLE) ||
                   ((state_q == RESP) && bus.resp_ready[owner_q]);
      accept     = can_accept && (bus.req_valid != 2'b00);
      req_ready  = 2'b00;
      if (accept) begin
         req_ready = winner ? 2'b10 : 2'b01;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      alu_rs1_d    = alu_rs1_q;
      alu_rs2_d    = alu_rs2_q;
      alu_opcode_d = alu_opcode_q;
      alu_funct3_d = alu_funct3_q;
      alu_funct7_d = alu_funct7_q;
      resp_data_d  = resp_data_q;
      resp_valid_d = resp_valid_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif

      case (state_q)
         EXEC: begin
            resp_data_d  = bus.alu_rd;
            resp_valid_d = owner_q ? 2'b10 : 2'b01;
            state_d      = RESP;
         end
         RESP: begin
            if (bus.resp_ready[owner_q]) begin
               resp_valid_d = 2'b00;
               state_d      = IDLE;
            end
         end
         default: ;
      endcase

      // Shared by IDLE and the back-to-back path out of RESP; accept is
      // never high in EXEC.
      if (accept) begin
         state_d      = EXEC;
         owner_d      = winner;
         alu_rs1_d    = winner ? bus.req_rs1_1    : bus.req_rs1_0;
         alu_rs2_d    = winner ? bus.req_rs2_1    : bus.req_rs2_0;
         alu_opcode_d = winner ? bus.req_opcode_1 : bus.req_opcode_0;
         alu_funct3_d = winner ? bus.req_funct3_1 : bus.req_funct3_0;
         alu_funct7_d = winner ? bus.req_funct7_1 : bus.req_funct7_0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         last_grant_d = winner;
`endif
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         alu_rs1_q    <= '0;
         alu_rs2_q    <= '0;
         alu_opcode_q <= '0;
         alu_funct3_q <= '0;
         alu_funct7_q <= '0;
         resp_data_q  <= '0;
         resp_valid_q <= 2'b00;
         busy_q       <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         // Starting at 1 lets port 0 win the first tie.
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         alu_rs1_q    <= alu_rs1_d;
         alu_rs2_q    <= alu_rs2_d;
         alu_opcode_q <= alu_opcode_d;
         alu_funct3_q <= alu_funct3_d;
         alu_funct7_q <= alu_funct7_d;
         resp_data_q  <= resp_data_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.alu_rs1    = alu_rs1_q;
   assign bus.alu_rs2    = alu_rs2_q;
   assign bus.alu_opcode = alu_opcode_q;
   assign bus.alu_funct3 = alu_funct3_q;
   assign bus.alu_funct7 = alu_funct7_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign busy           = busy_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_alu_arb.sv
module tb_alu_arb;
   localparam int XLEN = 32;
   localparam int OPW  = 7;
   localparam int F3W  = 3;
   localparam int F7W  = 7;
   localparam logic [6:0] OP_R = 7'b0110011;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   alu_arb_if #(.XLEN(XLEN), .OPW(OPW), .F3W(F3W), .F7W(F7W)) bus ();
   logic       busy;
   logic [1:0] dbg_state;

   alu_arb #(.XLEN(XLEN), .OPW(OPW), .F3W(F3W), .F7W(F7W)) dut (
      .clk      (clk),
      .rst      (rst_n),
      .bus      (bus),
      .busy     (busy),
      .dbg_state(dbg_state)
   );

   // ---------------- requester-side drive ----------------
   logic            v0, v1;
   logic [31:0]     rs1_0, rs2_0, rs1_1, rs2_1;
   logic [6:0]      op_0, op_1, f7_0, f7_1;
   logic [2:0]      f3_0, f3_1;
   logic [1:0]      rr;

   assign bus.req_valid    = {v1, v0};
   assign bus.req_rs1_0    = rs1_0;
   assign bus.req_rs2_0    = rs2_0;
   assign bus.req_rs1_1    = rs1_1;
   assign bus.req_rs2_1    = rs2_1;
   assign bus.req_opcode_0 = op_0;
   assign bus.req_opcode_1 = op_1;
   assign bus.req_funct3_0 = f3_0;
   assign bus.req_funct3_1 = f3_1;
   assign bus.req_funct7_0 = f7_0;
   assign bus.req_funct7_1 = f7_1;
   assign bus.resp_ready   = rr;

   // Behavioural ALU driving the combinational result.
   logic [31:0] alu_model;
   always_comb begin
      alu_model = '0;
      if (bus.alu_opcode == OP_R) begin
         case (bus.alu_funct3)
            3'd0: alu_model = bus.alu_funct7[5] ? bus.alu_rs1 - bus.alu_rs2
                                                : bus.alu_rs1 + bus.alu_rs2;
            3'd1: alu_model = bus.alu_rs1 << bus.alu_rs2[4:0];
            3'd4: alu_model = bus.alu_rs1 ^ bus.alu_rs2;
            3'd6: alu_model = bus.alu_rs1 | bus.alu_rs2;
            3'd7: alu_model = bus.alu_rs1 & bus.alu_rs2;
            default: alu_model = '0;
         endcase
      end
   end
   assign bus.alu_rd = alu_model;

   // ---------------- scoreboard ----------------
   logic [XLEN:0] exp_q[$];   // {port, data}
   int            grant_q[$];
   int            acc_cyc_q[$];
   int            n_cmp = 0;
   int            n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops an expectation on every completed response handshake.
   always @(negedge clk) begin
      if (rst_n && ((bus.resp_valid & bus.resp_ready) != 2'b00)) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL resp_unexpected: got resp_valid=%b data=0x%0h expected no response",
                     bus.resp_valid, bus.resp_data);
         end else begin
            logic [XLEN:0] e;
            e = exp_q.pop_front();
            check("resp_port", {62'd0, bus.resp_valid}, e[XLEN] ? 64'd2 : 64'd1);
            check("resp_data", {32'd0, bus.resp_data}, {32'd0, e[XLEN-1:0]});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic v, input logic [6:0] op,
                          input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b);
      if (p == 0) begin
         v0 = v; op_0 = op; f3_0 = f3; f7_0 = f7; rs1_0 = a; rs2_0 = b;
      end else begin
         v1 = v; op_1 = op; f3_1 = f3; f7_1 = f7; rs1_1 = a; rs2_1 = b;
      end
   endtask

   task automatic clr(input int p);
      if (p == 0) v0 = 1'b0;
      else        v1 = 1'b0;
   endtask

   task automatic push_exp(input int p, input logic [31:0] d);
      exp_q.push_back({p[0], d});
      grant_q.push_back(p);
      acc_cyc_q.push_back(cyc);
   endtask

   // Holds a request until accepted (bounded), then drops valid.
   task automatic issue(input int p, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] d);
      bit acc = 1'b0;
      set_req(p, 1'b1, op, f3, f7, a, b);
      for (int i = 0; i < 60 && !acc; i++) begin
         @(negedge clk);
         if (bus.req_ready[p]) begin
            acc = 1'b1;
            push_exp(p, d);
         end
         tick();
      end
      if (!acc) begin
         n_cmp++;
         n_err++;
         $display("FAIL issue_timeout: got no req_ready on port %0d expected accept", p);
      end
      clr(p);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Hand-computed XOR stream for port 1.
   logic [31:0] bb_a [4] = '{32'h1, 32'hF0, 32'hAA, 32'h1234};
   logic [31:0] bb_b [4] = '{32'h2, 32'h0F, 32'hFF, 32'h1234};
   logic [31:0] bb_r [4] = '{32'h3, 32'hFF, 32'h55, 32'h0};

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0;
      rr    = 2'b11;
      set_req(0, 1'b0, '0, '0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0, '0, '0);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      check("rst_resp_data", 64'(bus.resp_data), 64'd0);
      check("rst_alu_rs1", 64'(bus.alu_rs1), 64'd0);
      check("rst_alu_opcode", 64'(bus.alu_opcode), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single ADD on port 0
      set_req(0, 1'b1, OP_R, 3'd0, 7'd0, 32'd5, 32'd7);
      @(negedge clk);
      check("add_req_ready", 64'(bus.req_ready), 64'd1);
      check("add_busy_idle", 64'(busy), 64'd0);
      push_exp(0, 32'd12);
      tick();
      clr(0);
      @(negedge clk);
      check("add_busy_exec", 64'(busy), 64'd1);
      check("add_alu_rs1", 64'(bus.alu_rs1), 64'd5);
      check("add_alu_rs2", 64'(bus.alu_rs2), 64'd7);
      check("add_alu_opcode", 64'(bus.alu_opcode), 64'(OP_R));
      check("add_resp_early", 64'(bus.resp_valid), 64'd0);
      tick();
      @(negedge clk);
      check("add_busy_resp", 64'(busy), 64'd1);
      check("add_resp_valid", 64'(bus.resp_valid), 64'd1);
      check("add_resp_data", 64'(bus.resp_data), 64'd12);
      tick();
      @(negedge clk);
      check("add_busy_done", 64'(busy), 64'd0);
      check("add_idle_hold_rs1", 64'(bus.alu_rs1), 64'd5);
      check("add_idle_hold_data", 64'(bus.resp_data), 64'd12);
      tick();

      // Continuous tie: 8 ops per port, both valid
      pulse_reset();
      grant_q.delete();
      fork
         begin
            for (int i = 0; i < 8; i++)
               issue(0, OP_R, 3'd0, 7'd0, 32'(i), 32'd100, 32'(100 + i));
         end
         begin
            for (int i = 0; i < 8; i++)
               issue(1, OP_R, 3'd4, 7'd0, 32'(i), 32'hF0, 32'(i) ^ 32'hF0);
         end
      join
      wait_drain();
      check("tie_grant_count", 64'(grant_q.size()), 64'd16);
      for (int i = 0; i < 8 && i < grant_q.size(); i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
         check($sformatf("tie_grant_%0d", i), 64'(grant_q[i]), 64'(i % 2));
`else
         check($sformatf("tie_grant_%0d", i), 64'(grant_q[i]), 64'd0);
`endif
      end

      // Back-to-back XOR stream on port 1
      acc_cyc_q.delete();
      for (int i = 0; i < 4; i++)
         issue(1, OP_R, 3'd4, 7'd0, bb_a[i], bb_b[i], bb_r[i]);
      wait_drain();
      for (int i = 1; i < 4 && i < acc_cyc_q.size(); i++)
         check($sformatf("b2b_gap_%0d", i), 64'(acc_cyc_q[i] - acc_cyc_q[i-1]), 64'd2);

      // Response stall on port 0 with a competing port-1 request
      rr = 2'b10;
      set_req(0, 1'b1, OP_R, 3'd1, 7'd0, 32'd1, 32'd4);
      @(negedge clk);
      check("sll_req_ready", 64'(bus.req_ready), 64'd1);
      push_exp(0, 32'd16);
      tick();
      clr(0);
      set_req(1, 1'b1, OP_R, 3'd0, 7'd0, 32'd2, 32'd3);
      @(negedge clk);
      check("stall_exec_ready", 64'(bus.req_ready), 64'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("stall_valid_%0d", i), 64'(bus.resp_valid), 64'd1);
         check($sformatf("stall_data_%0d", i), 64'(bus.resp_data), 64'd16);
         check($sformatf("stall_ready1_%0d", i), 64'(bus.req_ready), 64'd0);
         tick();
      end
      rr = 2'b11;
      @(negedge clk);
      check("stall_release_ready", 64'(bus.req_ready), 64'd2);
      push_exp(1, 32'd5);
      tick();
      clr(1);
      @(negedge clk);
      check("stall_old_owner_drop", 64'(bus.resp_valid), 64'd0);
      wait_drain();

      // Reset in EXEC: SUB 10-3 is dropped
      set_req(0, 1'b1, OP_R, 3'd0, 7'h20, 32'd10, 32'd3);
      @(negedge clk);
      check("sub_req_ready", 64'(bus.req_ready), 64'd1);
      tick();
      clr(0);
      rst_n = 1'b0;
      #1;
      check("rexec_busy", 64'(busy), 64'd0);
      check("rexec_state", 64'(dbg_state), 64'd0);
      check("rexec_alu_rs1", 64'(bus.alu_rs1), 64'd0);
      check("rexec_alu_funct7", 64'(bus.alu_funct7), 64'd0);
      check("rexec_resp_data", 64'(bus.resp_data), 64'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("rexec_no_resp_%0d", i), 64'(bus.resp_valid), 64'd0);
         tick();
      end

      // Reset in RESP with resp_valid high
      rr = 2'b00;
      set_req(1, 1'b1, OP_R, 3'd6, 7'd0, 32'hF0, 32'h0F);
      @(negedge clk);
      check("or_req_ready", 64'(bus.req_ready), 64'd2);
      tick();
      clr(1);
      tick();
      @(negedge clk);
      check("rresp_valid_before", 64'(bus.resp_valid), 64'd2);
      check("rresp_data_before", 64'(bus.resp_data), 64'hFF);
      #1;
      rst_n = 1'b0;
      #1;
      check("rresp_valid_after", 64'(bus.resp_valid), 64'd0);
      check("rresp_busy_after", 64'(busy), 64'd0);
      tick();
      rst_n = 1'b1;
      rr = 2'b11;
      issue(1, OP_R, 3'd0, 7'd0, 32'd20, 32'd22, 32'd42);
      wait_drain();

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
